uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit buffer that sits directly upstream of the UART transmit controller. It accepts bytes from the host side into a circular FIFO and issues them one at a time to the controller. Each byte is presented as a one-cycle DATA_VLD pulse with a stable P_DATA word. The block then tracks the controller's BUSY flag so that exactly one byte is handed over per frame and no byte is lost or duplicated.

## Interface
- DATA_WIDTH, 8, width of each stored word and of P_DATA
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- ADDR_WIDTH, $clog2(DEPTH), derived; not overridden by instantiators
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-low
- WR_DATA  input  DATA_WIDTH  word to enqueue
- WR_EN  input  1  enqueue request
- FULL  output  1  FIFO holds DEPTH entries
- EMPTY  output  1  FIFO holds 0 entries
- BUSY  input  1  transmit controller busy (high from its START through STOP states)
- DATA_VLD  output  1  one-cycle issue strobe to the transmit controller
- P_DATA  output  DATA_WIDTH  issued word; held until the next issue
- OVERFLOW  output  1  sticky; present only with the configuration macro
- CLR_OVF  input  1  clears OVERFLOW; present only with the configuration macro
- LEVEL  output  ADDR_WIDTH+1  occupancy 0..DEPTH; present only with the configuration macro

## Operation
- Pointers: write and read pointers are ADDR_WIDTH+1 bits and wrap naturally.
  - EMPTY when the pointers are equal.
  - FULL when the MSBs differ and the lower bits are equal.
  - Count = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Write rule:
  - WR_EN && !FULL stores WR_DATA and increments wr_ptr.
  - WR_EN && FULL drops the word; pointers are unchanged.
  - FULL is evaluated at the start of the cycle, so a same-cycle pop does not make room for a write. The dropped write still counts as an overflow.
- Issue FSM, state in a registered variable:
  - IDLE: if !EMPTY && !BUSY, register the head word into P_DATA, set DATA_VLD=1, increment rd_ptr, and go to ISSUE. Otherwise stay.
  - ISSUE: DATA_VLD=0; go to WAIT_BUSY with the guard counter cleared.
  - WAIT_BUSY: if BUSY, go to WAIT_DONE. Otherwise increment the guard counter; after 4 cycles with no BUSY, return to IDLE and treat the byte as sent.
  - WAIT_DONE: when BUSY=0, go to IDLE.
  - Illegal encodings go to IDLE.
- Outputs are registered: DATA_VLD, P_DATA, FULL, EMPTY, and LEVEL when present.
- Simultaneous write and pop when neither FULL nor EMPTY: both pointers advance and the count is unchanged.
- Reset values: DATA_VLD=0, P_DATA=0, EMPTY=1, FULL=0, OVERFLOW=0, LEVEL=0. State = IDLE, pointers = 0, guard = 0.
- Reset asserted mid-frame discards all stored data. Storage contents are not cleared, because the pointers define validity.

## Timing
- Write accepted at edge N: EMPTY falls after edge N.
- Issue: with the FSM in IDLE and BUSY=0, DATA_VLD is high for the single cycle after edge N+1, with P_DATA valid in the same cycle.
- Controller handshake: the controller samples DATA_VLD at edge N+2 and BUSY rises after N+2. WAIT_BUSY then sees BUSY at edge N+3.
- Inter-frame gap: after BUSY falls, the next DATA_VLD occurs at the earliest 2 edges later.
- P_DATA never changes while BUSY=1.
- DATA_VLD is never high on two consecutive cycles.

## Configuration
- Macro: UART_TX_FIFO_STATUS_EN.
- Defined:
  - OVERFLOW, CLR_OVF and LEVEL exist.
  - OVERFLOW sets on any WR_EN && FULL and holds until CLR_OVF.
  - If CLR_OVF and a new overflow occur in the same cycle, set wins.
  - LEVEL equals the registered count.
- Undefined: those ports and their logic are absent. Drop behaviour is identical.

## Structure
- Shared package uart_pkg holds:
  - the issue-state typedef (IDLE=2'b00, ISSUE=2'b01, WAIT_BUSY=2'b10, WAIT_DONE=2'b11);
  - the guard timeout constant (4);
  - the default data width (8).
- One sub-module, uart_fifo_mem: DEPTH×DATA_WIDTH array with synchronous write, asynchronous read by address, and no reset.

## Test plan
- Reset, then write 0xA5 with BUSY held 0: DATA_VLD pulses exactly 2 cycles after the write edge with P_DATA=0xA5, and EMPTY returns to 1.
- Write 0x11, 0x22, 0x33 back-to-back; model BUSY high for 10 cycles per frame. Expect three DATA_VLD pulses carrying 11, 22, 33 in order, each no earlier than 2 cycles after BUSY falls.
- Hold BUSY=1 and write 17 words with DEPTH=16: FULL=1 after the 16th write and the 17th is dropped. With the macro, OVERFLOW=1, then clears one cycle after CLR_OVF; LEVEL=16.
- Write 2 words, assert RST low while DATA_VLD is high, then release: all outputs are at reset values and no further DATA_VLD occurs.
- BUSY stuck 0 after an issue: the FSM returns to IDLE after 4 guard cycles and issues the next word.
- With the FIFO full, apply a same-cycle WR_EN and pop: the write is dropped, the count becomes 15, and FULL deasserts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: the issue-FSM
// state encoding, the BUSY guard timeout and the default data width.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int GUARD_CYCLES   = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_BUSY = 2'b10,
        WAIT_DONE = 2'b11
    } issue_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read by address.
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; the FIFO pointers alone decide which
    // entries are live, and an unreset array can map onto RAM.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that hands one byte per frame to the UART TX controller.
// Define UART_TX_FIFO_STATUS_EN to add OVERFLOW/CLR_OVF/LEVEL status ports.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_EN,
    output logic                  FULL,
    output logic                  EMPTY,
`ifdef UART_TX_FIFO_STATUS_EN
    input  logic                  CLR_OVF,
    output logic                  OVERFLOW,
    output logic [ADDR_WIDTH:0]   LEVEL,
`endif
    input  logic                  BUSY,
    output logic                  DATA_VLD,
    output logic [DATA_WIDTH-1:0] P_DATA
);

    localparam int GUARD_W = $clog2(GUARD_CYCLES) + 1;

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    issue_state_e          state_q, state_d;
    logic [GUARD_W-1:0]    guard_q, guard_d;
    logic                  data_vld_q, data_vld_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  wr_fire;
    logic                  pop;

    // FULL is the registered flag, so a same-cycle pop never frees room.
    assign wr_fire = WR_EN && !full_q;

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .CLK       (CLK),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (WR_DATA),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (head_data)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d    = state_q;
        guard_d    = guard_q;
        data_vld_d = 1'b0;
        p_data_d   = p_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && !BUSY) begin
                    pop        = 1'b1;
                    data_vld_d = 1'b1;
                    p_data_d   = head_data;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                guard_d = '0;
            end
            WAIT_BUSY: begin
                if (BUSY) begin
                    state_d = WAIT_DONE;
                end else if (guard_q == GUARD_W'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!BUSY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_fire};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                   (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            state_q    <= IDLE;
            guard_q    <= '0;
            data_vld_q <= 1'b0;
            p_data_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            state_q    <= state_d;
            guard_q    <= guard_d;
            data_vld_q <= data_vld_d;
            p_data_q   <= p_data_d;
        end
    end

    assign FULL     = full_q;
    assign EMPTY    = empty_q;
    assign DATA_VLD = data_vld_q;
    assign P_DATA   = p_data_q;

`ifdef UART_TX_FIFO_STATUS_EN
    logic                overflow_q, overflow_d;
    logic [ADDR_WIDTH:0] level_q, level_d;

    // A new overflow in the same cycle as CLR_OVF keeps the flag set.
    always_comb begin
        overflow_d = (WR_EN && full_q) || (overflow_q && !CLR_OVF);
        level_d    = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q <= 1'b0;
            level_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            level_q    <= level_d;
        end
    end

    assign OVERFLOW = overflow_q;
    assign LEVEL    = level_q;
`else
    // Without status ports a full-FIFO write is still dropped by wr_fire.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a BUSY controller model and an
// issue scoreboard; status-port checks follow UART_TX_FIFO_STATUS_EN.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] WR_DATA = '0;
    logic          WR_EN = 1'b0;
    logic          FULL, EMPTY, BUSY, DATA_VLD;
    logic [DW-1:0] P_DATA;
`ifdef UART_TX_FIFO_STATUS_EN
    logic          CLR_OVF = 1'b0;
    logic          OVERFLOW;
    logic [AW:0]   LEVEL;
`endif

    always #5 CLK = ~CLK;

    uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_DATA  (WR_DATA),
        .WR_EN    (WR_EN),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
`ifdef UART_TX_FIFO_STATUS_EN
        .CLR_OVF  (CLR_OVF),
        .OVERFLOW (OVERFLOW),
        .LEVEL    (LEVEL),
`endif
        .BUSY     (BUSY),
        .DATA_VLD (DATA_VLD),
        .P_DATA   (P_DATA)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Controller model: BUSY high for 10 cycles after each sampled DATA_VLD.
    logic auto_busy = 1'b0;
    logic busy_force = 1'b0;
    logic model_busy;
    int   busy_cnt;
    assign BUSY = auto_busy ? model_busy : busy_force;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (auto_busy && DATA_VLD) begin
            model_busy <= 1'b1;
            busy_cnt   <= 10;
        end else if (busy_cnt > 1) begin
            busy_cnt   <= busy_cnt - 1;
        end else begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    logic [DW-1:0] exp_q[$];
    int            cyc = 0;
    int            fall_cyc = 0;
    logic          fell = 1'b0;
    logic          prev_vld = 1'b0;
    logic          prev_busy = 1'b0;
    logic [DW-1:0] prev_pdata = '0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (DATA_VLD) begin
            check("vld_single_cycle", {31'b0, prev_vld}, 32'd0);
            if (exp_q.size() == 0) begin
                check("vld_unexpected", 32'd1, 32'd0);
            end else begin
                check("issue_data", {24'b0, P_DATA}, {24'b0, exp_q.pop_front()});
            end
            if (fell) begin
                check("gap_after_busy", {31'b0, (cyc - fall_cyc) >= 2}, 32'd1);
                fell = 1'b0;
            end
        end
        if (BUSY && prev_busy) check("pdata_stable_busy", {24'b0, P_DATA}, {24'b0, prev_pdata});
        if (auto_busy && prev_busy && !BUSY) begin
            fell     = 1'b1;
            fall_cyc = cyc;
        end
        prev_vld   = DATA_VLD;
        prev_busy  = BUSY;
        prev_pdata = P_DATA;
    end

    task automatic next_cycle();
        @(negedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_vld"}, {31'b0, DATA_VLD}, 32'd0);
        check({tag, "_p_data"}, {24'b0, P_DATA}, 32'd0);
        check({tag, "_empty"}, {31'b0, EMPTY}, 32'd1);
        check({tag, "_full"}, {31'b0, FULL}, 32'd0);
`ifdef UART_TX_FIFO_STATUS_EN
        check({tag, "_overflow"}, {31'b0, OVERFLOW}, 32'd0);
        check({tag, "_level"}, {27'b0, LEVEL}, 32'd0);
`endif
    endtask

    task automatic wait_drain(input int budget, input int settle);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        check("drain_done", exp_q.size(), 32'd0);
        repeat (settle) next_cycle();
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          accept;
        logic          exp_full;
        logic          exp_empty;
        logic [AW:0]   exp_level;
    } vec_t;

    vec_t vecs[DEPTH + 1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i <= DEPTH; i++) begin
            vecs[i].data      = 8'h40 + 8'(i);
            vecs[i].accept    = (i < DEPTH);
            vecs[i].exp_full  = (i >= DEPTH - 1);
            vecs[i].exp_empty = 1'b0;
            vecs[i].exp_level = (i < DEPTH) ? (AW + 1)'(i + 1) : (AW + 1)'(DEPTH);
        end

        // Reset values, then a single write with BUSY low.
        next_cycle();
        check_reset_outputs("reset");
        RST = 1'b1;
        next_cycle();
        WR_EN = 1'b1;
        WR_DATA = 8'hA5;
        exp_q.push_back(8'hA5);
        next_cycle();
        WR_EN = 1'b0;
        check("single_empty_falls", {31'b0, EMPTY}, 32'd0);
        check("single_no_early_vld", {31'b0, DATA_VLD}, 32'd0);
        next_cycle();
        check("single_vld", {31'b0, DATA_VLD}, 32'd1);
        check("single_pdata", {24'b0, P_DATA}, 32'hA5);
        check("single_empty_again", {31'b0, EMPTY}, 32'd1);
        next_cycle();
        check("single_vld_drops", {31'b0, DATA_VLD}, 32'd0);
        repeat (10) next_cycle();

        // Three back-to-back writes against the 10-cycle BUSY model.
        auto_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            WR_EN = 1'b1;
            WR_DATA = 8'(8'h11 * i);
            exp_q.push_back(8'(8'h11 * i));
            next_cycle();
        end
        WR_EN = 1'b0;
        wait_drain(200, 20);

        // Fill to 17 writes with BUSY held high; the last one is dropped.
        auto_busy = 1'b0;
        busy_force = 1'b1;
        next_cycle();
        for (int i = 0; i <= DEPTH; i++) begin
            WR_EN = 1'b1;
            WR_DATA = vecs[i].data;
            if (vecs[i].accept) exp_q.push_back(vecs[i].data);
            next_cycle();
            check($sformatf("fill_full_%0d", i), {31'b0, FULL}, {31'b0, vecs[i].exp_full});
            check($sformatf("fill_empty_%0d", i), {31'b0, EMPTY}, {31'b0, vecs[i].exp_empty});
`ifdef UART_TX_FIFO_STATUS_EN
            check($sformatf("fill_level_%0d", i), {27'b0, LEVEL}, {27'b0, vecs[i].exp_level});
`endif
        end
        WR_EN = 1'b0;
`ifdef UART_TX_FIFO_STATUS_EN
        check("overflow_set", {31'b0, OVERFLOW}, 32'd1);
        CLR_OVF = 1'b1;
        next_cycle();
        CLR_OVF = 1'b0;
        check("overflow_cleared", {31'b0, OVERFLOW}, 32'd0);
        check("level_full", {27'b0, LEVEL}, 32'd16);
`else
        next_cycle();
`endif
        check("still_full", {31'b0, FULL}, 32'd1);

        // Full FIFO: same-cycle write and pop drops the write.
        WR_EN = 1'b1;
        WR_DATA = 8'hEE;
        busy_force = 1'b0;
        next_cycle();
        WR_EN = 1'b0;
        auto_busy = 1'b1;
        check("pop_full_deasserts", {31'b0, FULL}, 32'd0);
        check("pop_vld", {31'b0, DATA_VLD}, 32'd1);
`ifdef UART_TX_FIFO_STATUS_EN
        check("pop_level_15", {27'b0, LEVEL}, 32'd15);
        check("pop_overflow", {31'b0, OVERFLOW}, 32'd1);
`endif
        wait_drain(600, 20);
        check("drained_empty", {31'b0, EMPTY}, 32'd1);

        // BUSY stuck low: guard timeout, then the next word issues.
        auto_busy = 1'b0;
        busy_force = 1'b0;
        WR_EN = 1'b1;
        WR_DATA = 8'h5A;
        exp_q.push_back(8'h5A);
        next_cycle();
        WR_DATA = 8'hC3;
        exp_q.push_back(8'hC3);
        check("guard_no_vld_yet", {31'b0, DATA_VLD}, 32'd0);
        next_cycle();
        WR_EN = 1'b0;
        check("guard_first_vld", {31'b0, DATA_VLD}, 32'd1);
        check("guard_first_data", {24'b0, P_DATA}, 32'h5A);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check($sformatf("guard_quiet_%0d", k), {31'b0, DATA_VLD}, 32'd0);
        end
        next_cycle();
        check("guard_second_vld", {31'b0, DATA_VLD}, 32'd1);
        check("guard_second_data", {24'b0, P_DATA}, 32'hC3);
        repeat (10) next_cycle();

        // Reset asserted while DATA_VLD is high discards the queued word.
        WR_EN = 1'b1;
        WR_DATA = 8'h77;
        exp_q.push_back(8'h77);
        next_cycle();
        WR_DATA = 8'h88;
        next_cycle();
        WR_EN = 1'b0;
        check("rst_mid_vld", {31'b0, DATA_VLD}, 32'd1);
        RST = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        exp_q.delete();
        next_cycle();
        RST = 1'b1;
        repeat (20) next_cycle();
        check_reset_outputs("rst_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
